// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the smolproc memory/write-back stage.
package mem_stage_pkg;

    // EX_sig_ctrl_DM decoded: bit 1 selects load data for write-back, bit 0 stores.
    typedef struct packed {
        logic sel_mem;
        logic write;
    } dm_ctrl_t;

    localparam int DM_WRITE_BIT = 0;
    localparam int DM_SEL_BIT   = 1;
    localparam int NOP_INSTR    = 0;

endpackage

// File: rtl/mem_stage_dpram.sv
// True dual-port RAM: port A is a read-only fetch port with enable, port B is read-first read/write.
// Each port has one registered output, cleared by the synchronous reset; contents are never cleared.
module mem_stage_dpram
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = "dedotated_wam.mif"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] d_b,
    output logic [DATA_W-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_W;

    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= DATA_W'(NOP_INSTR);
        end else if (en_a) begin
            q_a <= mem[addr_a];
        end
    end

    // Read-first: the old word is registered while the new word is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_b <= '0;
        end else begin
            q_b <= mem[addr_b];
        end
        if (we_b && !rst) begin
            mem[addr_b] <= d_b;
        end
    end

endmodule

// File: rtl/mem_stage_param.sv
// Memory/write-back stage: shared fetch/data RAM, RD_STAGES-deep alignment pipes and write-back mux.
// Optional macro MEM_STAGE_WR_FWD_EN forwards store data to a colliding fetch (write-first on port A).
module mem_stage_param
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int REG_ADDR_W = 2,
    parameter int RD_STAGES  = 1,
    parameter     INIT_FILE  = "dedotated_wam.mif"
) (
    input  logic                  sig_clk,
    input  logic                  sig_rst,
    input  logic [ADDR_W-1:0]     IF_addr_pgm,
    input  logic                  IF_sig_stall,
    output logic [DATA_W-1:0]     ID_EX_data_pgm,
    input  logic                  EX_sig_valid,
    input  logic                  sig_flush,
    input  logic [DATA_W-1:0]     EX_data_result,
    input  logic [DATA_W-1:0]     EX_data_reg,
    input  logic [REG_ADDR_W-1:0] EX_addr_reg,
    input  logic [1:0]            EX_sig_ctrl_DM,
    input  logic                  EX_sig_ctrl_RF,
    output logic [REG_ADDR_W-1:0] RF_addr_write,
    output logic [DATA_W-1:0]     RF_data_write,
    output logic                  RF_sig_ctrl_RF
);

    if (RD_STAGES != 1 && RD_STAGES != 2) begin : g_bad_rd_stages
        $error("mem_stage_param: RD_STAGES must be 1 or 2");
    end

    // An EX slot takes effect only when valid, not flushed and not in reset.
    dm_ctrl_t          dm_ctrl;
    logic              live;
    logic              store_live;
    logic              wb_en_in;
    logic              fetch_en;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] ram_q_a;
    logic [DATA_W-1:0] ram_q_b;
    logic [DATA_W-1:0] fetch_word;

    always_comb begin
        dm_ctrl         = '0;
        dm_ctrl.write   = EX_sig_ctrl_DM[DM_WRITE_BIT];
        dm_ctrl.sel_mem = EX_sig_ctrl_DM[DM_SEL_BIT];
    end

    assign live       = EX_sig_valid & ~sig_flush & ~sig_rst;
    assign store_live = live & dm_ctrl.write;
    assign wb_en_in   = live & EX_sig_ctrl_RF;
    assign fetch_en   = ~IF_sig_stall;

    if (DATA_W >= ADDR_W) begin : g_addr_slice
        assign dm_addr = EX_data_result[ADDR_W-1:0];
    end else begin : g_addr_zext
        assign dm_addr = {{(ADDR_W-DATA_W){1'b0}}, EX_data_result};
    end

    mem_stage_dpram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk    (sig_clk),
        .rst    (sig_rst),
        .en_a   (fetch_en),
        .addr_a (IF_addr_pgm),
        .q_a    (ram_q_a),
        .we_b   (store_live),
        .addr_b (dm_addr),
        .d_b    (EX_data_reg),
        .q_b    (ram_q_b)
    );

`ifdef MEM_STAGE_WR_FWD_EN
    // Collision flag and store data are registered alongside the port-A read and hold with it.
    logic              fwd_hit_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge sig_clk) begin
        if (sig_rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else if (fetch_en) begin
            fwd_hit_q  <= store_live && (IF_addr_pgm == dm_addr);
            fwd_data_q <= EX_data_reg;
        end
    end

    assign fetch_word = fwd_hit_q ? fwd_data_q : ram_q_a;
`else
    assign fetch_word = ram_q_a;
`endif

    // First alignment stage: matches the RAM's registered port-B output.
    logic                  s1_wb_en;
    logic                  s1_sel;
    logic [REG_ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0]     s1_result;

    always_ff @(posedge sig_clk) begin
        if (sig_rst) begin
            s1_wb_en  <= 1'b0;
            s1_sel    <= 1'b0;
            s1_addr   <= '0;
            s1_result <= '0;
        end else begin
            s1_wb_en  <= wb_en_in;
            s1_sel    <= dm_ctrl.sel_mem;
            s1_addr   <= EX_addr_reg;
            s1_result <= EX_data_result;
        end
    end

    logic                  al_wb_en;
    logic                  al_sel;
    logic [REG_ADDR_W-1:0] al_addr;
    logic [DATA_W-1:0]     al_result;
    logic [DATA_W-1:0]     al_load;
    logic [DATA_W-1:0]     al_pgm;

    if (RD_STAGES == 2) begin : g_two_stage
        logic                  s2_wb_en;
        logic                  s2_sel;
        logic [REG_ADDR_W-1:0] s2_addr;
        logic [DATA_W-1:0]     s2_result;
        logic [DATA_W-1:0]     s2_load;
        logic [DATA_W-1:0]     s2_pgm;

        always_ff @(posedge sig_clk) begin
            if (sig_rst) begin
                s2_wb_en  <= 1'b0;
                s2_sel    <= 1'b0;
                s2_addr   <= '0;
                s2_result <= '0;
                s2_load   <= '0;
            end else begin
                s2_wb_en  <= s1_wb_en;
                s2_sel    <= s1_sel;
                s2_addr   <= s1_addr;
                s2_result <= s1_result;
                s2_load   <= ram_q_b;
            end
        end

        // Fetch pipe freezes as a whole together with the port-A read.
        always_ff @(posedge sig_clk) begin
            if (sig_rst) begin
                s2_pgm <= DATA_W'(NOP_INSTR);
            end else if (fetch_en) begin
                s2_pgm <= fetch_word;
            end
        end

        assign al_wb_en  = s2_wb_en;
        assign al_sel    = s2_sel;
        assign al_addr   = s2_addr;
        assign al_result = s2_result;
        assign al_load   = s2_load;
        assign al_pgm    = s2_pgm;
    end else begin : g_one_stage
        assign al_wb_en  = s1_wb_en;
        assign al_sel    = s1_sel;
        assign al_addr   = s1_addr;
        assign al_result = s1_result;
        assign al_load   = ram_q_b;
        assign al_pgm    = fetch_word;
    end

    assign ID_EX_data_pgm = al_pgm;
    assign RF_sig_ctrl_RF = al_wb_en;
    assign RF_addr_write  = al_addr;
    assign RF_data_write  = al_sel ? al_load : al_result;

endmodule
